// File: rtl/i2s_receiver_pkg.sv
// Shared audio package: default sample/slot/FIFO sizes and the receiver
// FSM state encodings.
package i2s_receiver_pkg;

    localparam int SAMPLE_WIDTH_DEF = 24;
    localparam int SLOT_LEN         = 32;
    localparam int FIFO_DEPTH_DEF   = 4;

    // Bit counter saturates at 63, so it is 6 bits wide.
    localparam int                  BITCNT_W   = 6;
    localparam logic [BITCNT_W-1:0] BITCNT_MAX = 6'd63;

    // Receiver FSM states.
    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

endpackage

// File: rtl/i2s_receiver_sync_fifo.sv
// Single-clock frame FIFO. The head word is shown combinationally and reads
// as zero while the FIFO is empty. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == DEPTH_CNT);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + ONE_PTR;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ONE_PTR;
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain, deserialises
// left/right slots and buffers complete stereo frames in a FIFO.
//
// Frame handshake: frame_valid high means frame_out_l/r hold the oldest
// frame; a one-cycle read_frame while frame_valid is high consumes it,
// read_frame while frame_valid is low has no effect.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           bclk,
    input  logic                           lrclk,
    input  logic                           sdata,
    output logic [SAMPLE_WIDTH-1:0]        frame_out_l,
    output logic [SAMPLE_WIDTH-1:0]        frame_out_r,
    output logic                           frame_valid,
    input  logic                           read_frame,
    output logic                           overflow,
    output logic                           framing_error,
    input  logic                           clear_flags,
    output logic [1:0]                     dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]    dbg_count
);
    localparam logic [BITCNT_W-1:0] SW_CNT = BITCNT_W'(SAMPLE_WIDTH);

    logic [1:0]                r_bclk_sync;
    logic [1:0]                r_lr_sync;
    logic [1:0]                r_sd_sync;
    logic                      r_bclk_prev;
    logic                      r_lr_prev;
    logic [BITCNT_W-1:0]       r_bitcnt;
    logic [SAMPLE_WIDTH-1:0]   r_shift;
    logic [SAMPLE_WIDTH-1:0]   r_left;
    logic                      r_left_ok;
    logic [1:0]                r_state;
    logic                      r_overflow;
    logic                      r_framing_error;

    logic                      w_bclk_rise;
    logic                      w_lr;
    logic                      w_sd;
    logic                      w_boundary;
    logic                      w_slot_full;
    logic                      w_to_right;
    logic                      w_to_left;
    logic                      w_push;
    logic                      w_frame_err;
    logic                      w_full;
    logic                      w_empty;
    logic [2*SAMPLE_WIDTH-1:0] w_push_data;
    logic [2*SAMPLE_WIDTH-1:0] w_head;

    // Two-flop synchronizers for all I2S inputs plus a bclk history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sd_sync   <= '0;
            r_bclk_prev <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], bclk};
            r_lr_sync   <= {r_lr_sync[0], lrclk};
            r_sd_sync   <= {r_sd_sync[0], sdata};
            r_bclk_prev <= r_bclk_sync[1];
        end
    end

    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_prev;
    assign w_lr        = r_lr_sync[1];
    assign w_sd        = r_sd_sync[1];
    assign w_boundary  = w_bclk_rise & (w_lr ^ r_lr_prev);
    assign w_slot_full = (r_bitcnt >= SW_CNT);
    assign w_to_right  = w_boundary & (r_state == ST_LEFT) & w_lr;
    assign w_to_left   = w_boundary & (r_state == ST_RIGHT) & ~w_lr;
    assign w_push      = w_to_left & w_slot_full & r_left_ok;
    assign w_frame_err = (w_to_right & ~w_slot_full)
                       | (w_to_left & ~(w_slot_full & r_left_ok));
    assign w_push_data = {r_left, r_shift};

    // Bit counter and MSB-first shifter; the boundary edge carries the
    // previous slot's LSB, so it only restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lr_prev <= 1'b0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
        end else if (w_bclk_rise) begin
            r_lr_prev <= w_lr;
            if (w_boundary) begin
                r_bitcnt <= '0;
            end else begin
                if (r_bitcnt < SW_CNT) begin
                    r_shift <= {r_shift[SAMPLE_WIDTH-2:0], w_sd};
                end
                if (r_bitcnt != BITCNT_MAX) begin
                    r_bitcnt <= r_bitcnt + BITCNT_W'(1);
                end
            end
        end
    end

    // Slot-tracking FSM; latches the left sample when the left slot closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SYNC;
            r_left    <= '0;
            r_left_ok <= 1'b0;
        end else if (w_boundary) begin
            case (r_state)
                ST_SYNC: begin
                    if (!w_lr) r_state <= ST_LEFT;
                end
                ST_LEFT: begin
                    if (w_lr) begin
                        r_state <= ST_RIGHT;
                        if (w_slot_full) begin
                            r_left    <= r_shift;
                            r_left_ok <= 1'b1;
                        end else begin
                            r_left_ok <= 1'b0;
                        end
                    end
                end
                ST_RIGHT: begin
                    if (!w_lr) r_state <= ST_LEFT;
                end
                default: r_state <= ST_SYNC;
            endcase
        end
    end

    // Sticky status flags; a new event wins over clear_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            if (w_push && w_full && !read_frame) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_err) begin
                r_framing_error <= 1'b1;
            end else if (clear_flags) begin
                r_framing_error <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (read_frame),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (dbg_count)
    );

    assign frame_valid   = ~w_empty;
    assign frame_out_l   = w_head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign frame_out_r   = w_head[SAMPLE_WIDTH-1:0];
    assign overflow      = r_overflow;
    assign framing_error = r_framing_error;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives an I2S stream bit by bit and
// checks captured frames against an expected queue.
module tb_i2s_receiver;
    import i2s_receiver_pkg::*;

    localparam int SW    = 24;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic              read_frame;
    logic              clear_flags;
    logic [SW-1:0]     frame_out_l;
    logic [SW-1:0]     frame_out_r;
    logic              frame_valid;
    logic              overflow;
    logic              framing_error;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_count;

    int                n_checks = 0;
    int                n_errors = 0;
    int                half     = 20;
    logic              cur_lr   = 1'b0;
    logic [2*SW-1:0]   exp_q[$];

    i2s_receiver #(
        .SAMPLE_WIDTH (SW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .frame_out_l   (frame_out_l),
        .frame_out_r   (frame_out_r),
        .frame_valid   (frame_valid),
        .read_frame    (read_frame),
        .overflow      (overflow),
        .framing_error (framing_error),
        .clear_flags   (clear_flags),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bclk period: data changes on the falling edge, sampled on rising.
    // mode 1: check frame_valid around a push into an empty FIFO.
    // mode 2: pop on the exact cycle of a push into a full FIFO.
    task automatic send_bit(input logic lr, input logic b, input int mode);
        @(posedge clk); #1;
        bclk = 1'b0; lrclk = lr; sdata = b;
        repeat (half) @(posedge clk);
        #1; bclk = 1'b1;
        case (mode)
            1: begin
                repeat (3) @(negedge clk);
                check("valid_before_push", frame_valid, 1'b0);
                @(negedge clk);
                check("valid_after_push", frame_valid, 1'b1);
                repeat (half - 4) @(posedge clk);
            end
            2: begin
                repeat (3) @(negedge clk);
                check("pp_cnt_pre", dbg_count, 3'd4);
                check("pp_head", {frame_out_l, frame_out_r}, exp_q[0]);
                read_frame = 1'b1;
                @(negedge clk);
                read_frame = 1'b0;
                void'(exp_q.pop_front());
                check("pp_cnt_post", dbg_count, 3'd4);
                check("pp_ovf", overflow, 1'b0);
                repeat (half - 4) @(posedge clk);
            end
            default: repeat (half - 1) @(posedge clk);
        endcase
    endtask

    // Slot edges first..last-1; edge 0 is the lrclk boundary (sent only if
    // lrclk actually changes), edges 1..SW carry data MSB first, rest pad 1.
    task automatic send_slot(input logic lr, input logic [SW-1:0] d,
                             input int first, input int last, input int mode);
        logic b;
        for (int i = first; i < last; i++) begin
            if (i == 0 && lr == cur_lr) continue;
            b = (i >= 1 && i <= SW) ? d[SW-i] : 1'b1;
            send_bit(lr, b, (i == 0) ? mode : 0);
        end
        cur_lr = lr;
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int mode);
        send_slot(1'b0, l, 0, 32, mode);
        send_slot(1'b1, r, 0, 32, 0);
    endtask

    // Falling lrclk boundary that completes the preceding right slot.
    task automatic close_frame(input int mode);
        send_slot(1'b0, '0, 0, 1, mode);
    endtask

    task automatic read_chk(input string tag);
        logic [2*SW-1:0] exp;
        @(negedge clk);
        check({tag, "_valid"}, frame_valid, 1'b1);
        exp = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
        check({tag, "_data"}, {frame_out_l, frame_out_r}, exp);
        read_frame = 1'b1;
        @(negedge clk);
        read_frame = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    initial begin
        logic [SW-1:0] l;
        logic [SW-1:0] r;

        // Reset
        reset = 1'b1; bclk = 1'b1; lrclk = 1'b0; sdata = 1'b0;
        read_frame = 1'b0; clear_flags = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_out", {frame_out_l, frame_out_r}, 48'h0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", framing_error, 1'b0);
        check("rst_state", dbg_state, ST_SYNC);
        check("rst_count", dbg_count, 3'd0);

        // Join mid right slot, then one full frame at bclk = clk/40
        send_slot(1'b1, 24'hFFFFFF, 10, 32, 0);
        @(negedge clk);
        check("sync_hold", dbg_state, ST_SYNC);
        send_frame(24'h123456, 24'hABCDEF, 0);
        @(negedge clk);
        check("state_right", dbg_state, ST_RIGHT);
        check("no_partial", frame_valid, 1'b0);
        exp_q.push_back({24'h123456, 24'hABCDEF});
        close_frame(1);
        @(negedge clk);
        check("state_left", dbg_state, ST_LEFT);
        read_chk("basic");
        @(negedge clk);
        check("basic_drained", frame_valid, 1'b0);

        // Pop while empty is ignored
        read_frame = 1'b1;
        @(negedge clk);
        read_frame = 1'b0;
        @(negedge clk);
        check("empty_pop_cnt", dbg_count, 3'd0);

        half = 5;

        // Short left slot (12 bits)
        send_slot(1'b0, 24'h0F0F0F, 0, 13, 0);
        send_slot(1'b1, 24'h333333, 0, 32, 0);
        @(negedge clk);
        check("short_ferr", framing_error, 1'b1);
        check("short_state", dbg_state, ST_RIGHT);
        send_frame(24'h5A5A5A, 24'hC3C3C3, 0);
        @(negedge clk);
        check("short_no_push", frame_valid, 1'b0);
        exp_q.push_back({24'h5A5A5A, 24'hC3C3C3});
        close_frame(0);
        read_chk("short_next");
        pulse_clear();
        check("ferr_cleared", framing_error, 1'b0);

        // Overflow: five frames, no reads
        for (int k = 1; k <= 5; k++) begin
            l = 24'(k * 24'h111111);
            r = ~l;
            send_frame(l, r, 0);
            if (k <= 4) exp_q.push_back({l, r});
        end
        @(negedge clk);
        check("ovf_cnt4", dbg_count, 3'd4);
        check("ovf_before", overflow, 1'b0);
        close_frame(0);
        @(negedge clk);
        check("ovf_set", overflow, 1'b1);
        check("ovf_cnt_hold", dbg_count, 3'd4);
        for (int k = 1; k <= 4; k++) read_chk($sformatf("ovf_rd%0d", k));
        @(negedge clk);
        check("ovf_empty", frame_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        pulse_clear();
        check("ovf_cleared", overflow, 1'b0);

        // Push and pop together while full
        for (int k = 1; k <= 5; k++) begin
            l = 24'h0C0DE0 | 24'(k);
            r = 24'hFEED00 | 24'(k);
            send_frame(l, r, 0);
            if (k <= 4) exp_q.push_back({l, r});
        end
        close_frame(2);
        exp_q.push_back({24'h0C0DE5, 24'hFEED05});
        @(negedge clk);
        check("pp_cnt", dbg_count, 3'd4);
        check("pp_ovf_after", overflow, 1'b0);
        for (int k = 1; k <= 4; k++) read_chk($sformatf("pp_rd%0d", k));
        @(negedge clk);
        check("pp_empty", frame_valid, 1'b0);

        // Reset during bit 5 of a right slot
        send_frame(24'hDEAD01, 24'hBEEF02, 0);
        send_slot(1'b0, 24'h0F0F0F, 0, 13, 0);
        send_slot(1'b1, 24'h777777, 0, 6, 0);
        @(negedge clk);
        check("pre_rst_valid", frame_valid, 1'b1);
        check("pre_rst_ferr", framing_error, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_valid", frame_valid, 1'b0);
        check("mid_rst_ferr", framing_error, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_out", {frame_out_l, frame_out_r}, 48'h0);
        check("mid_rst_state", dbg_state, ST_SYNC);
        exp_q.delete();
        send_slot(1'b1, 24'h777777, 6, 32, 0);
        send_frame(24'h13579B, 24'h2468AC, 0);
        @(negedge clk);
        check("rst_no_partial", frame_valid, 1'b0);
        exp_q.push_back({24'h13579B, 24'h2468AC});
        close_frame(0);
        read_chk("rst_next");
        @(negedge clk);
        check("final_empty", frame_valid, 1'b0);
        check("final_ferr", framing_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
